// File: rtl/cfg_frame_rx.sv
// -----------------------------------------------------------------------------
// cfg_frame_rx
//
// Fabric-side receiver for the word-parallel configuration bus. Owns
// NUM_FRAMES consecutive one-hot enable slots starting at BASE and captures one
// configuration word per slot, on the falling edge of that slot's enable. Once
// every owned slot has been written and ff_en releases the fabric, the frames
// are presented to the tile with cfg_valid. Protocol violations latch a sticky
// error until reset.
//
// Optional feature macro: CFG_RX_READBACK_EN
//   defined   : rb_data is a registered copy of frame[rb_sel] (1-cycle latency)
//   undefined : rb_data is tied to zero, no readback mux is built
//
// Ports
//   clock      in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   configs_en in   [EN_W]   one-hot slot enable from the loader
//   configs_in in   [WORD_W] configuration word
//   ff_en      in   fabric run enable (level)
//   cfg_out    out  [NUM_FRAMES*WORD_W] frame i at [i*WORD_W +: WORD_W]
//   cfg_valid  out  frames are live (RUN state)
//   loaded     out  every owned frame has been captured
//   err        out  sticky protocol error
//   err_code   out  01 multi-hot, 10 write in RUN, 11 ff_en before loaded
//   rb_sel     in   readback frame select
//   rb_data    out  [WORD_W] readback word
// -----------------------------------------------------------------------------
module cfg_frame_rx #(
    parameter int WORD_W     = 224,
    parameter int EN_W       = 245,
    parameter int NUM_FRAMES = 4,
    parameter int BASE       = 0
) (
    input  logic                                               clock,
    input  logic                                               rst,
    input  logic [EN_W-1:0]                                    configs_en,
    input  logic [WORD_W-1:0]                                  configs_in,
    input  logic                                               ff_en,
    output logic [NUM_FRAMES*WORD_W-1:0]                       cfg_out,
    output logic                                               cfg_valid,
    output logic                                               loaded,
    output logic                                               err,
    output logic [1:0]                                         err_code,
    input  logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] rb_sel,
    output logic [WORD_W-1:0]                                  rb_data
);

    localparam logic [2:0] S_EMPTY   = 3'd0;
    localparam logic [2:0] S_LOADING = 3'd1;
    localparam logic [2:0] S_LOADED  = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;

    localparam logic [NUM_FRAMES-1:0] ONE = NUM_FRAMES'(1);

    logic [2:0]            state_q, state_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [NUM_FRAMES-1:0] wr_mask_q, wr_mask_d;
    logic [NUM_FRAMES-1:0] en_q;        // owned enable slice, one cycle old
    logic [WORD_W-1:0]     data_q;      // configs_in, one cycle old
    logic [WORD_W-1:0]     frame_q [NUM_FRAMES];
    logic [WORD_W-1:0]     rb_q;

    logic [NUM_FRAMES-1:0] en_now;
    logic [NUM_FRAMES-1:0] cap;
    logic [NUM_FRAMES-1:0] wr_en;
    logic                  any_cap;
    logic                  multi_hot;
    logic                  unused_en;

    assign en_now    = configs_en[BASE +: NUM_FRAMES];
    // Bits outside the owned window are deliberately ignored.
    assign unused_en = ^configs_en;

    // A slot is captured when its enable falls; data_q then still holds the
    // last word presented while the slot was selected.
    assign cap       = en_q & ~en_now;
    assign any_cap   = |cap;
    // x & (x-1) clears the lowest set bit: non-zero means two or more set.
    assign multi_hot = |(en_now & (en_now - ONE));

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        wr_mask_d  = wr_mask_q;
        wr_en      = '0;
        if (state_q != S_ERROR) begin
            // Error checks in priority order 01 > 10 > 11; any error blocks
            // the capture of the same cycle.
            if (multi_hot) begin
                state_d    = S_ERROR;
                err_code_d = 2'b01;
            end else if (any_cap && (state_q == S_RUN)) begin
                state_d    = S_ERROR;
                err_code_d = 2'b10;
            end else if (ff_en && ((state_q == S_EMPTY) || (state_q == S_LOADING))) begin
                state_d    = S_ERROR;
                err_code_d = 2'b11;
            end else begin
                wr_en     = cap;
                wr_mask_d = wr_mask_q | cap;
                case (state_q)
                    S_EMPTY:   if (any_cap) state_d = (&wr_mask_d) ? S_LOADED : S_LOADING;
                    S_LOADING: if (&wr_mask_d) state_d = S_LOADED;
                    S_LOADED:  if (ff_en) state_d = S_RUN;
                    S_RUN:     if (!ff_en) state_d = S_LOADED;
                    default:   state_d = S_ERROR;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q    <= S_EMPTY;
            err_code_q <= '0;
            wr_mask_q  <= '0;
            en_q       <= '0;
            data_q     <= '0;
            for (int unsigned i = 0; i < NUM_FRAMES; i++) begin
                frame_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            wr_mask_q  <= wr_mask_d;
            en_q       <= en_now;
            data_q     <= configs_in;
            for (int unsigned i = 0; i < NUM_FRAMES; i++) begin
                if (wr_en[i]) begin
                    frame_q[i] <= data_q;
                end
            end
        end
    end

    always_comb begin
        cfg_out = '0;
        if (state_q != S_ERROR) begin
            for (int unsigned i = 0; i < NUM_FRAMES; i++) begin
                cfg_out[i*WORD_W +: WORD_W] = frame_q[i];
            end
        end
    end

    assign cfg_valid = (state_q == S_RUN);
    assign loaded    = &wr_mask_q;
    assign err       = (state_q == S_ERROR);
    assign err_code  = err_code_q;

`ifdef CFG_RX_READBACK_EN
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            rb_q <= '0;
        end else if (int'(rb_sel) < NUM_FRAMES) begin
            rb_q <= frame_q[rb_sel];
        end else begin
            rb_q <= '0;
        end
    end
`else
    logic unused_rb_sel;
    assign unused_rb_sel = ^rb_sel;
    assign rb_q          = '0;
`endif

    assign rb_data = rb_q;

endmodule

// File: tb/tb_cfg_frame_rx.sv
module tb_cfg_frame_rx;

    localparam int WORD_W = 224;
    localparam int EN_W   = 245;
    localparam int NF     = 4;

    logic                 clock;
    logic                 rst;
    logic [EN_W-1:0]      configs_en;
    logic [WORD_W-1:0]    configs_in;
    logic                 ff_en;
    logic [NF*WORD_W-1:0] cfg_out;
    logic                 cfg_valid;
    logic                 loaded;
    logic                 err;
    logic [1:0]           err_code;
    logic [1:0]           rb_sel;
    logic [WORD_W-1:0]    rb_data;

    cfg_frame_rx #(
        .WORD_W     (WORD_W),
        .EN_W       (EN_W),
        .NUM_FRAMES (NF),
        .BASE       (0)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .configs_en (configs_en),
        .configs_in (configs_in),
        .ff_en      (ff_en),
        .cfg_out    (cfg_out),
        .cfg_valid  (cfg_valid),
        .loaded     (loaded),
        .err        (err),
        .err_code   (err_code),
        .rb_sel     (rb_sel),
        .rb_data    (rb_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       r;
        logic [7:0] en;
        logic [7:0] d;
        logic       ff;
        logic [1:0] rbsel;
        logic [7:0] f3, f2, f1, f0;
        logic       valid, ld, er;
        logic [1:0] code;
        logic       chk_rb;
        logic [7:0] rb;
    } vec_t;

    typedef struct {
        int                   id;
        logic [NF*WORD_W-1:0] out;
        logic                 valid, ld, er;
        logic [1:0]           code;
        logic                 chk_rb;
        logic [WORD_W-1:0]    rb;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;
    int   vid  = 0;

    function automatic logic [WORD_W-1:0] w(input logic [7:0] b);
        return {28{b}};
    endfunction

    function automatic void v(input logic r, input logic [7:0] en, input logic [7:0] d,
                              input logic ff, input logic [1:0] rbsel,
                              input logic [7:0] f3, input logic [7:0] f2,
                              input logic [7:0] f1, input logic [7:0] f0,
                              input logic valid, input logic ld, input logic er,
                              input logic [1:0] code, input logic chk_rb, input logic [7:0] rb);
        vec_t t;
        t.r = r; t.en = en; t.d = d; t.ff = ff; t.rbsel = rbsel;
        t.f3 = f3; t.f2 = f2; t.f1 = f1; t.f0 = f0;
        t.valid = valid; t.ld = ld; t.er = er; t.code = code;
        t.chk_rb = chk_rb; t.rb = rb;
        tbl.push_back(t);
    endfunction

    function automatic logic [WORD_W-1:0] rb_exp(input logic [7:0] b);
`ifdef CFG_RX_READBACK_EN
        return w(b);
`else
        return (b == 8'h00) ? '0 : '0;
`endif
    endfunction

    task automatic check(input exp_t e);
        nvec++;
        if (cfg_out !== e.out) begin
            nerr++;
            $display("FAIL vec%0d cfg_out got %h exp %h", e.id, cfg_out, e.out);
        end
        if (cfg_valid !== e.valid) begin
            nerr++;
            $display("FAIL vec%0d cfg_valid got %b exp %b", e.id, cfg_valid, e.valid);
        end
        if (loaded !== e.ld) begin
            nerr++;
            $display("FAIL vec%0d loaded got %b exp %b", e.id, loaded, e.ld);
        end
        if (err !== e.er) begin
            nerr++;
            $display("FAIL vec%0d err got %b exp %b", e.id, err, e.er);
        end
        if (err_code !== e.code) begin
            nerr++;
            $display("FAIL vec%0d err_code got %b exp %b", e.id, err_code, e.code);
        end
        if (e.chk_rb && (rb_data !== e.rb)) begin
            nerr++;
            $display("FAIL vec%0d rb_data got %h exp %h", e.id, rb_data, e.rb);
        end
    endtask

    // Drain the vector table: drive each row at the falling edge, queue its
    // expectation, and compare just after the following rising edge.
    task automatic run_rows();
        vec_t t;
        exp_t e;
        while (tbl.size() > 0) begin
            t = tbl.pop_front();
            @(negedge clock);
            rst        = t.r;
            configs_en = '0;
            configs_en[7:0] = t.en;
            configs_in = w(t.d);
            ff_en      = t.ff;
            rb_sel     = t.rbsel;
            e.id     = vid++;
            e.out    = {w(t.f3), w(t.f2), w(t.f1), w(t.f0)};
            e.valid  = t.valid;
            e.ld     = t.ld;
            e.er     = t.er;
            e.code   = t.code;
            e.chk_rb = t.chk_rb;
            e.rb     = rb_exp(t.rb);
            sb.push_back(e);
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL scoreboard empty at vec%0d", vid);
            end else begin
                check(sb.pop_front());
            end
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic mid_cycle_reset();
        exp_t e;
        #2;
        rst = 1'b0;
        #1;
        e.id = vid++; e.out = '0; e.valid = 1'b0; e.ld = 1'b0; e.er = 1'b0;
        e.code = 2'b00; e.chk_rb = 1'b1; e.rb = '0;
        check(e);
        @(negedge clock);
        configs_en = '0;
        ff_en      = 1'b0;
        @(negedge clock);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; configs_en = '0; configs_in = '0; ff_en = 1'b0; rb_sel = '0;

        // Reset, nominal walk over bits 0..4, RUN/LOADED toggle, write in RUN
        v(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 1, 8'h00);
        v(1, 8'h01, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h01, 8'hA1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h02, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h00, 8'hA1, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h02, 8'hB2, 0, 0, 8'h00, 8'h00, 8'h00, 8'hA1, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h04, 8'h5A, 0, 0, 8'h00, 8'h00, 8'hB2, 8'hA1, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h04, 8'hC3, 0, 0, 8'h00, 8'h00, 8'hB2, 8'hA1, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h08, 8'h5A, 0, 0, 8'h00, 8'hC3, 8'hB2, 8'hA1, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h08, 8'hD4, 0, 0, 8'h00, 8'hC3, 8'hB2, 8'hA1, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h10, 8'h5A, 0, 0, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 0, 1, 0, 2'b00, 0, 8'h00);
        v(1, 8'h10, 8'hEE, 0, 2, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 0, 1, 0, 2'b00, 1, 8'hC3);
        v(1, 8'h00, 8'h5A, 1, 3, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 1, 1, 0, 2'b00, 1, 8'hD4);
        v(1, 8'h00, 8'h5A, 0, 0, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 0, 1, 0, 2'b00, 0, 8'h00);
        v(1, 8'h04, 8'h77, 0, 0, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 0, 1, 0, 2'b00, 0, 8'h00);
        v(1, 8'h00, 8'h5A, 0, 0, 8'hD4, 8'h77, 8'hB2, 8'hA1, 0, 1, 0, 2'b00, 0, 8'h00);
        v(1, 8'h00, 8'h5A, 1, 2, 8'hD4, 8'h77, 8'hB2, 8'hA1, 1, 1, 0, 2'b00, 1, 8'h77);
        v(1, 8'h01, 8'h99, 1, 0, 8'hD4, 8'h77, 8'hB2, 8'hA1, 1, 1, 0, 2'b00, 0, 8'h00);
        v(1, 8'h00, 8'h5A, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1, 2'b10, 1, 8'hA1);
        v(1, 8'h00, 8'h5A, 0, 2, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1, 2'b10, 1, 8'h77);
        v(1, 8'h01, 8'h11, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1, 2'b10, 0, 8'h00);
        v(1, 8'h00, 8'h11, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1, 2'b10, 0, 8'h00);
        v(1, 8'h00, 8'h11, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1, 2'b10, 1, 8'hA1);
        run_rows();

        // Reset while in ERROR with loaded=1: must clear without a clock edge
        mid_cycle_reset();

        // Overwrite slot 1, then ff_en with only slots 0..2 loaded
        v(1, 8'h02, 8'h55, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h00, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h55, 8'h00, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h02, 8'h66, 0, 0, 8'h00, 8'h00, 8'h55, 8'h00, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h00, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h66, 8'h00, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h01, 8'h10, 0, 0, 8'h00, 8'h00, 8'h66, 8'h00, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h04, 8'h20, 0, 0, 8'h00, 8'h00, 8'h66, 8'h10, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h00, 8'h5A, 0, 2, 8'h00, 8'h20, 8'h66, 8'h10, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h00, 8'h5A, 1, 2, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 2'b11, 1, 8'h20);
        v(1, 8'h00, 8'h5A, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 2'b11, 1, 8'h66);
        // Multi-hot together with early ff_en: multi-hot wins, later captures ignored
        v(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 1, 8'h00);
        v(1, 8'h01, 8'hA1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h00, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h00, 8'hA1, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h03, 8'h33, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 2'b01, 1, 8'hA1);
        v(1, 8'h00, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 2'b01, 0, 8'h00);
        v(1, 8'h04, 8'h44, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 2'b01, 0, 8'h00);
        v(1, 8'h00, 8'h5A, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 2'b01, 1, 8'h00);
        v(1, 8'h00, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 2'b01, 1, 8'hA1);
        // Partial load ahead of a mid-load reset
        v(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 1, 8'h00);
        v(1, 8'h01, 8'h12, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h02, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h00, 8'h12, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h02, 8'h23, 0, 0, 8'h00, 8'h00, 8'h00, 8'h12, 0, 0, 0, 2'b00, 1, 8'h12);
        run_rows();

        mid_cycle_reset();

        // Loading resumes cleanly after reset
        v(1, 8'h00, 8'h5A, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 1, 8'h00);
        v(1, 8'h01, 8'h21, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h02, 8'h32, 0, 0, 8'h00, 8'h00, 8'h00, 8'h21, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h04, 8'h43, 0, 0, 8'h00, 8'h00, 8'h32, 8'h21, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h08, 8'h54, 0, 0, 8'h00, 8'h43, 8'h32, 8'h21, 0, 0, 0, 2'b00, 0, 8'h00);
        v(1, 8'h00, 8'h5A, 0, 3, 8'h54, 8'h43, 8'h32, 8'h21, 0, 1, 0, 2'b00, 0, 8'h00);
        v(1, 8'h00, 8'h5A, 1, 3, 8'h54, 8'h43, 8'h32, 8'h21, 1, 1, 0, 2'b00, 1, 8'h54);
        run_rows();

        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard residue got %0d exp 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/cfg_frame_rx.md
# cfg_frame_rx

Configuration frame receiver: the fabric-side end of the word-parallel configuration bus (one-hot `configs_en`, shared `configs_in`). It owns `NUM_FRAMES` consecutive enable slots starting at `BASE` and captures one configuration word per slot. It then presents the frames to its tile once `ff_en` releases the fabric, and flags any protocol violation on the bus.

## Interface
Parameters:
- `WORD_W`, 224: configuration word width.
- `EN_W`, 245: full width of the one-hot enable bus.
- `NUM_FRAMES`, 4: enable slots / frames owned by this instance (1..16).
- `BASE`, 0: index of the first owned bit in `configs_en`; `BASE+NUM_FRAMES <= EN_W`.

Ports:
- `clock`, in, 1: sole clock; all logic on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `configs_en`, in, `EN_W`: one-hot slot enable from the loader.
- `configs_in`, in, `WORD_W`: configuration word.
- `ff_en`, in, 1: fabric run enable; level.
- `cfg_out`, out, `NUM_FRAMES*WORD_W`: frame i is at `[i*WORD_W +: WORD_W]`.
- `cfg_valid`, out, 1: high in RUN only.
- `loaded`, out, 1: all owned frames captured.
- `err`, out, 1: sticky protocol error.
- `err_code`, out, 2: 01 multi-hot, 10 write during RUN, 11 `ff_en` before loaded; 00 otherwise.
- `rb_sel`, in, `$clog2(NUM_FRAMES)` (min 1): readback frame select.
- `rb_data`, out, `WORD_W`: readback word.

## Operation
- Each cycle the block registers the owned enable slice (`en_d`) and `configs_in` (`data_d`).
- Capture rule: slot i is written on the falling edge of its enable, i.e. `en_d[i] & ~en[i]` writes `frame[i] <= data_d`. This captures the last word present while the slot was selected.
- `wr_mask[i]` is set on capture of slot i. `loaded = &wr_mask`.
- Rewriting a slot before RUN is legal: the new word overwrites the old one, with no error.
- States:
  - EMPTY: reset state; `wr_mask` = 0.
  - EMPTY -> LOADING on the first capture.
  - LOADING -> LOADED when `wr_mask` becomes all-ones.
  - LOADED -> RUN when `ff_en` = 1.
  - RUN -> LOADED when `ff_en` returns to 0. Frames are retained, and reloading is legal in LOADED.
- Error entry, from any state:
  - More than one owned enable bit high in the same sample: go to ERROR with code 01.
  - A capture event while in RUN: go to ERROR with code 10. The frame is not updated.
  - `ff_en` = 1 while in EMPTY or LOADING: go to ERROR with code 11.
  - If several errors occur in the same cycle, priority is 01 > 10 > 11.
- ERROR behaviour: sticky until `rst`. `cfg_out` is forced to all-zero, `cfg_valid` = 0, and captures are ignored.
- Enable bits outside `[BASE, BASE+NUM_FRAMES)` are ignored entirely.
- `cfg_out` reflects the frame registers in every state except ERROR. The tile gates on `cfg_valid`.

## Timing
- Reset values: `cfg_out` = 0, `cfg_valid` = 0, `loaded` = 0, `err` = 0, `err_code` = 00, `rb_data` = 0. Frames, `wr_mask`, `en_d` and `data_d` are all cleared; state = EMPTY.
- Capture latency: if `configs_en[BASE+i]` is sampled high at edge n and low at edge n+1, `frame[i]` holds the word sampled at edge n after edge n+1.
- `loaded`, state and `err` update at the same edge as the causing event (registered, 0-cycle output skew).
- `cfg_valid` rises at the edge sampling `ff_en` = 1 in LOADED, and falls at the edge sampling `ff_en` = 0.
- A slot still high when `ff_en` rises has not been captured. That case is covered by code 11 unless the slot was already written earlier.
- Reset asserted mid-load clears everything immediately (asynchronous). Loading resumes cleanly after deassertion.

## Configuration
- `CFG_RX_READBACK_EN` defined: `rb_data` is a registered copy of `frame[rb_sel]` with 1-cycle latency, valid in all states including ERROR, for loader-side verification. Out-of-range `rb_sel` returns 0.
- `CFG_RX_READBACK_EN` undefined: the ports remain present, `rb_data` is tied to 0, and no readback mux is built.

## Test plan
- Nominal load (BASE=0, N=4): walk the one-hot over bits 0..4, each held for 2 cycles, with words A1, B2, C3, D4 in the second cycle of each hold. Required: `loaded` = 1 after the bit3 fall, and `cfg_out` = {D4,C3,B2,A1}. Then `ff_en` = 1 gives `cfg_valid` = 1 the next edge.
- Overwrite: load slot 1 with 55, reload it with 66 before completion. Required: frame1 = 66, `err` = 0.
- Multi-hot: `configs_en` = 0b0011 for one cycle. Required: `err` = 1, `err_code` = 01, `cfg_out` = 0, and later captures are ignored.
- Early run: only slots 0–2 loaded, `ff_en` = 1. Required: `err_code` = 11, `cfg_valid` stays 0.
- Write in RUN, then RUN/LOADED toggle:
  - After RUN, drop `ff_en`: state = LOADED with frames intact. Reload slot 2 = 77 and re-enable: `cfg_valid` = 1 with frame2 = 77.
  - Pulse slot 0 while RUN: `err_code` = 10, frame0 unchanged via readback.
- Readback and reset: with the macro defined, `rb_sel` = 2 returns C3 one cycle later. Asserting `rst` mid-load clears all outputs to 0 immediately.
